branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_pkg.sv | 26 ++
 rtl/sat_counter2.sv | 44 ++++
 rtl/branch_predictor.sv | 153 +++++++++++++++
 tb/tb_branch_predictor.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared branch definitions.
// Provides the branch_operation encoding used by the execute-stage branch
// logic and the predictor, the default predictor size, and the 2-bit
// saturating counter encodings.
package branch_pkg;

  localparam int unsigned DEFAULT_ENTRIES = 16;

  // Code 3'b111 is intentionally left unnamed; the predictor treats it,
  // like BLTU/BGEU, as an ordinary conditional branch.
  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLT  = 3'd3,
    BR_BGE  = 3'd4,
    BR_BLTU = 3'd5,
    BR_BGEU = 3'd6
  } branch_operation;

  localparam logic [1:0] CNT_WEAK_NT   = 2'b01;
  localparam logic [1:0] CNT_WEAK_T    = 2'b10;
  localparam logic [1:0] CNT_STRONG_T  = 2'b11;
  localparam logic [1:0] CNT_STRONG_NT = 2'b00;

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating up/down counter with parallel load.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (resets to weakly not taken)
//   load_i       load load_val_i (highest priority)
//   load_val_i   value to load
//   inc_i/dec_i  count up / down, saturating at 3 / 0
//   cnt_o        current count
module sat_counter2
  import branch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [1:0] load_val_i,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [1:0] cnt_o
);

  logic [1:0] cnt_q;
  logic [1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i && (cnt_q != CNT_STRONG_T)) begin
      cnt_d = cnt_q + 2'd1;
    end else if (dec_i && (cnt_q != CNT_STRONG_NT)) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= CNT_WEAK_NT;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target predictor with 2-bit saturating counters.
// Fetch side (combinational from registered state):
//   PCF -> PredictTakenF, PredictTargetF
// Execute side (resolution, update, redirect):
//   ValidE, PCE, BranchE, JumpE, ActualTakenE, ActualTargetE, PCPlus4E,
//   PredictedTakenE, PredictedTargetE -> MispredictE, RedirectPC, FlushD, FlushE
// Performance counters: BranchCount, MispredictCount (wrap modulo 2^32).
module branch_predictor
  import branch_pkg::*;
#(
  parameter int unsigned ENTRIES = DEFAULT_ENTRIES,
  parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PCF,
  output logic        PredictTakenF,
  output logic [31:0] PredictTargetF,
  input  logic        ValidE,
  input  logic [31:0] PCE,
  input  logic [2:0]  BranchE,
  input  logic [1:0]  JumpE,
  input  logic        ActualTakenE,
  input  logic [31:0] ActualTargetE,
  input  logic [31:0] PCPlus4E,
  input  logic        PredictedTakenE,
  input  logic [31:0] PredictedTargetE,
  output logic        MispredictE,
  output logic [31:0] RedirectPC,
  output logic        FlushD,
  output logic        FlushE,
  output logic [31:0] BranchCount,
  output logic [31:0] MispredictCount
);

  localparam int unsigned TAG_W = 32 - IDX_W - 2;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       cnt      [ENTRIES];

  logic [IDX_W-1:0] f_idx, e_idx;
  logic [TAG_W-1:0] f_tag, e_tag;
  logic             f_hit, e_hit;
  logic             resolving, is_jump;

  logic [ENTRIES-1:0] cnt_load, cnt_inc, cnt_dec;
  logic [1:0]         cnt_load_val;
  logic               wr_entry, wr_target;

  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mp_cnt_q, mp_cnt_d;

  // Instructions are word aligned; the low PC bits carry no information.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{PCF[1:0], PCE[1:0]};

  assign f_idx = PCF[IDX_W+1:2];
  assign f_tag = PCF[31:IDX_W+2];
  assign e_idx = PCE[IDX_W+1:2];
  assign e_tag = PCE[31:IDX_W+2];

  // Fetch reads registered state only, so a same-cycle update is seen next cycle.
  assign f_hit          = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign PredictTakenF  = f_hit && cnt[f_idx][1];
  assign PredictTargetF = PredictTakenF ? target_q[f_idx] : '0;

  assign is_jump   = (JumpE != 2'd0);
  assign resolving = ValidE && ((branch_operation'(BranchE) != BR_NONE) || is_jump);
  assign e_hit     = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

  assign MispredictE = resolving &&
                       ((ActualTakenE != PredictedTakenE) ||
                        (ActualTakenE && (PredictedTargetE != ActualTargetE)));
  assign RedirectPC  = ActualTakenE ? ActualTargetE : PCPlus4E;
  assign FlushD      = MispredictE;
  assign FlushE      = MispredictE;

  // Update decode: jumps and tag misses allocate the entry and load the
  // counter; conditional hits just step the counter.
  always_comb begin
    cnt_load     = '0;
    cnt_inc      = '0;
    cnt_dec      = '0;
    cnt_load_val = CNT_WEAK_NT;
    wr_entry     = 1'b0;
    wr_target    = resolving && ActualTakenE;
    if (resolving) begin
      if (is_jump) begin
        wr_entry        = 1'b1;
        cnt_load[e_idx] = 1'b1;
        cnt_load_val    = CNT_STRONG_T;
      end else if (e_hit) begin
        cnt_inc[e_idx] = ActualTakenE;
        cnt_dec[e_idx] = !ActualTakenE;
      end else begin
        wr_entry        = 1'b1;
        cnt_load[e_idx] = 1'b1;
        cnt_load_val    = ActualTakenE ? CNT_WEAK_T : CNT_WEAK_NT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else begin
      if (wr_entry) begin
        valid_q[e_idx] <= 1'b1;
        tag_q[e_idx]   <= e_tag;
      end
      if (wr_target) begin
        target_q[e_idx] <= ActualTargetE;
      end
    end
  end

  for (genvar g = 0; g < ENTRIES; g++) begin : g_cnt
    sat_counter2 u_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (cnt_load[g]),
      .load_val_i (cnt_load_val),
      .inc_i      (cnt_inc[g]),
      .dec_i      (cnt_dec[g]),
      .cnt_o      (cnt[g])
    );
  end

  always_comb begin
    branch_cnt_d = branch_cnt_q + (resolving ? 32'd1 : 32'd0);
    mp_cnt_d     = mp_cnt_q + (MispredictE ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q <= '0;
      mp_cnt_q     <= '0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      mp_cnt_q     <= mp_cnt_d;
    end
  end

  assign BranchCount     = branch_cnt_q;
  assign MispredictCount = mp_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (ENTRIES=16, IDX_W=4).
module tb_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic [31:0] PCF;
  logic        PredictTakenF;
  logic [31:0] PredictTargetF;
  logic        ValidE;
  logic [31:0] PCE;
  logic [2:0]  BranchE;
  logic [1:0]  JumpE;
  logic        ActualTakenE;
  logic [31:0] ActualTargetE;
  logic [31:0] PCPlus4E;
  logic        PredictedTakenE;
  logic [31:0] PredictedTargetE;
  logic        MispredictE;
  logic [31:0] RedirectPC;
  logic        FlushD;
  logic        FlushE;
  logic [31:0] BranchCount;
  logic [31:0] MispredictCount;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] NONE = 3'd0;
  localparam logic [2:0] BEQ  = 3'd1;
  localparam logic [2:0] BNE  = 3'd2;
  localparam logic [2:0] BLTU = 3'd5;
  localparam logic [2:0] B111 = 3'd7;

  branch_predictor #(.ENTRIES(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .PCF              (PCF),
    .PredictTakenF    (PredictTakenF),
    .PredictTargetF   (PredictTargetF),
    .ValidE           (ValidE),
    .PCE              (PCE),
    .BranchE          (BranchE),
    .JumpE            (JumpE),
    .ActualTakenE     (ActualTakenE),
    .ActualTargetE    (ActualTargetE),
    .PCPlus4E         (PCPlus4E),
    .PredictedTakenE  (PredictedTakenE),
    .PredictedTargetE (PredictedTargetE),
    .MispredictE      (MispredictE),
    .RedirectPC       (RedirectPC),
    .FlushD           (FlushD),
    .FlushE           (FlushE),
    .BranchCount      (BranchCount),
    .MispredictCount  (MispredictCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running exp finished");
    $fatal(1, "timeout");
  end

  task automatic drive_e(input logic v, input logic [31:0] pc, input logic [2:0] br,
                         input logic [1:0] jmp, input logic tk, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt);
    ValidE           = v;
    PCE              = pc;
    BranchE          = br;
    JumpE            = jmp;
    ActualTakenE     = tk;
    ActualTargetE    = tgt;
    PCPlus4E         = pc + 32'd4;
    PredictedTakenE  = ptk;
    PredictedTargetE = ptgt;
  endtask

  // Commit on the next rising edge, then leave execute idle.
  task automatic step();
    @(posedge clk);
    #1;
    ValidE = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    PCF   = 32'h100;
    drive_e(1'b0, 32'h0, NONE, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    #2;
    checks++; if (PredictTakenF !== 1'b0) begin errors++; $display("FAIL reset_pt: got %b exp 0", PredictTakenF); end
    checks++; if (PredictTargetF !== 32'h0) begin errors++; $display("FAIL reset_ptgt: got %h exp 0", PredictTargetF); end
    checks++; if (BranchCount !== 32'd0) begin errors++; $display("FAIL reset_bc: got %0d exp 0", BranchCount); end
    checks++; if (MispredictCount !== 32'd0) begin errors++; $display("FAIL reset_mc: got %0d exp 0", MispredictCount); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (PredictTakenF !== 1'b0) begin errors++; $display("FAIL reset_pt_after: got %b exp 0", PredictTakenF); end
  endtask

  task automatic test_branch_learn();
    PCF = 32'h100;
    drive_e(1'b1, 32'h100, BEQ, 2'd0, 1'b1, 32'h80, 1'b0, 32'h0);
    #1;
    checks++; if (MispredictE !== 1'b1) begin errors++; $display("FAIL learn1_mp: got %b exp 1", MispredictE); end
    checks++; if (RedirectPC !== 32'h80) begin errors++; $display("FAIL learn1_redir: got %h exp 80", RedirectPC); end
    checks++; if (FlushD !== 1'b1 || FlushE !== 1'b1) begin errors++; $display("FAIL learn1_flush: got %b%b exp 11", FlushD, FlushE); end
    checks++; if (PredictTakenF !== 1'b0) begin errors++; $display("FAIL learn1_pre: got %b exp 0", PredictTakenF); end
    step();
    checks++; if (PredictTakenF !== 1'b1) begin errors++; $display("FAIL learn1_pt: got %b exp 1", PredictTakenF); end
    checks++; if (PredictTargetF !== 32'h80) begin errors++; $display("FAIL learn1_tgt: got %h exp 80", PredictTargetF); end
    checks++; if (MispredictE !== 1'b0) begin errors++; $display("FAIL learn1_idle_mp: got %b exp 0", MispredictE); end
    drive_e(1'b1, 32'h100, BEQ, 2'd0, 1'b1, 32'h80, 1'b1, 32'h80);
    #1;
    checks++; if (MispredictE !== 1'b0 || FlushD !== 1'b0) begin errors++; $display("FAIL learn2_mp: got %b%b exp 00", MispredictE, FlushD); end
    step();
    checks++; if (PredictTakenF !== 1'b1) begin errors++; $display("FAIL learn2_pt: got %b exp 1", PredictTakenF); end
  endtask

  task automatic test_mispredict_not_taken();
    PCF = 32'h100;
    drive_e(1'b1, 32'h100, BEQ, 2'd0, 1'b0, 32'h80, 1'b1, 32'h80);
    #1;
    checks++; if (MispredictE !== 1'b1) begin errors++; $display("FAIL nt1_mp: got %b exp 1", MispredictE); end
    checks++; if (RedirectPC !== 32'h104) begin errors++; $display("FAIL nt1_redir: got %h exp 104", RedirectPC); end
    checks++; if (FlushD !== 1'b1 || FlushE !== 1'b1) begin errors++; $display("FAIL nt1_flush: got %b%b exp 11", FlushD, FlushE); end
    step();
    checks++; if (FlushD !== 1'b0 || FlushE !== 1'b0) begin errors++; $display("FAIL nt1_flush_width: got %b%b exp 00", FlushD, FlushE); end
    // Counter 3 -> 2: still predicted taken, target retained.
    checks++; if (PredictTakenF !== 1'b1) begin errors++; $display("FAIL nt1_pt: got %b exp 1", PredictTakenF); end
    checks++; if (PredictTargetF !== 32'h80) begin errors++; $display("FAIL nt1_tgt: got %h exp 80", PredictTargetF); end
    drive_e(1'b1, 32'h100, BEQ, 2'd0, 1'b0, 32'h80, 1'b1, 32'h80);
    step();
    checks++; if (PredictTakenF !== 1'b0) begin errors++; $display("FAIL nt2_pt: got %b exp 0", PredictTakenF); end
    checks++; if (PredictTargetF !== 32'h0) begin errors++; $display("FAIL nt2_tgt: got %h exp 0", PredictTargetF); end
  endtask

  task automatic test_jump();
    PCF = 32'h200;
    drive_e(1'b1, 32'h200, NONE, 2'd1, 1'b1, 32'h400, 1'b0, 32'h0);
    #1;
    checks++; if (MispredictE !== 1'b1) begin errors++; $display("FAIL jal_mp: got %b exp 1", MispredictE); end
    checks++; if (RedirectPC !== 32'h400) begin errors++; $display("FAIL jal_redir: got %h exp 400", RedirectPC); end
    step();
    checks++; if (PredictTakenF !== 1'b1 || PredictTargetF !== 32'h400) begin errors++; $display("FAIL jal_pt: got %b/%h exp 1/400", PredictTakenF, PredictTargetF); end
    PCF = 32'h100;
    #1;
    checks++; if (PredictTakenF !== 1'b0) begin errors++; $display("FAIL jal_replaced: got %b exp 0", PredictTakenF); end
    PCF = 32'h240;
    #1;
    checks++; if (PredictTakenF !== 1'b0 || PredictTargetF !== 32'h0) begin errors++; $display("FAIL alias_miss: got %b/%h exp 0/0", PredictTakenF, PredictTargetF); end
    // Non-resolving valid instruction: no mispredict, no state change.
    PCF = 32'h200;
    drive_e(1'b1, 32'h200, NONE, 2'd0, 1'b0, 32'h0, 1'b1, 32'h400);
    #1;
    checks++; if (MispredictE !== 1'b0) begin errors++; $display("FAIL nonres_mp: got %b exp 0", MispredictE); end
    step();
    // Jump loaded counter 3: one not-taken resolution still leaves it predicted.
    drive_e(1'b1, 32'h200, BEQ, 2'd0, 1'b0, 32'h400, 1'b1, 32'h400);
    step();
    checks++; if (PredictTakenF !== 1'b1 || PredictTargetF !== 32'h400) begin errors++; $display("FAIL jal_cnt3: got %b/%h exp 1/400", PredictTakenF, PredictTargetF); end
  endtask

  task automatic test_same_cycle();
    PCF = 32'h104;
    drive_e(1'b1, 32'h104, BNE, 2'd0, 1'b1, 32'h500, 1'b0, 32'h0);
    #1;
    checks++; if (PredictTakenF !== 1'b0 || PredictTargetF !== 32'h0) begin errors++; $display("FAIL same_old: got %b/%h exp 0/0", PredictTakenF, PredictTargetF); end
    step();
    checks++; if (PredictTakenF !== 1'b1 || PredictTargetF !== 32'h500) begin errors++; $display("FAIL same_new: got %b/%h exp 1/500", PredictTakenF, PredictTargetF); end
  endtask

  task automatic test_back_to_back();
    // Reset lands in the middle of a pending update; it must be discarded.
    PCF = 32'h104;
    drive_e(1'b1, 32'h104, BNE, 2'd0, 1'b1, 32'h500, 1'b1, 32'h500);
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (PredictTakenF !== 1'b0) begin errors++; $display("FAIL midrst_pt: got %b exp 0", PredictTakenF); end
    checks++; if (BranchCount !== 32'd0 || MispredictCount !== 32'd0) begin errors++; $display("FAIL midrst_cnt: got %0d/%0d exp 0/0", BranchCount, MispredictCount); end
    ValidE = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (PredictTakenF !== 1'b0) begin errors++; $display("FAIL midrst_after: got %b exp 0", PredictTakenF); end

    drive_e(1'b1, 32'h100, BEQ,  2'd0, 1'b1, 32'h80,  1'b0, 32'h0);   step(); // mispredict
    drive_e(1'b1, 32'h100, BEQ,  2'd0, 1'b1, 32'h80,  1'b1, 32'h80);  step();
    drive_e(1'b1, 32'h100, BEQ,  2'd0, 1'b1, 32'h80,  1'b1, 32'h80);  step();
    drive_e(1'b1, 32'h104, BNE,  2'd0, 1'b0, 32'h0,   1'b0, 32'h0);   step();
    drive_e(1'b1, 32'h104, BNE,  2'd0, 1'b0, 32'h0,   1'b0, 32'h0);   step();
    drive_e(1'b1, 32'h108, NONE, 2'd1, 1'b1, 32'h700, 1'b0, 32'h0);   step(); // mispredict
    drive_e(1'b1, 32'h108, NONE, 2'd1, 1'b1, 32'h700, 1'b1, 32'h700); step();
    drive_e(1'b1, 32'h100, BEQ,  2'd0, 1'b1, 32'h90,  1'b1, 32'h80);
    #1;
    checks++; if (MispredictE !== 1'b1 || RedirectPC !== 32'h90) begin errors++; $display("FAIL tgt_mismatch: got %b/%h exp 1/90", MispredictE, RedirectPC); end
    step();
    drive_e(1'b1, 32'h10C, B111, 2'd0, 1'b1, 32'h600, 1'b1, 32'h600); step();
    drive_e(1'b1, 32'h110, BLTU, 2'd0, 1'b0, 32'h0,   1'b0, 32'h0);   step();

    checks++; if (BranchCount !== 32'd10) begin errors++; $display("FAIL branch_count: got %0d exp 10", BranchCount); end
    checks++; if (MispredictCount !== 32'd3) begin errors++; $display("FAIL mispredict_count: got %0d exp 3", MispredictCount); end
    PCF = 32'h100; #1;
    checks++; if (PredictTakenF !== 1'b1 || PredictTargetF !== 32'h90) begin errors++; $display("FAIL b2b_100: got %b/%h exp 1/90", PredictTakenF, PredictTargetF); end
    PCF = 32'h104; #1;
    checks++; if (PredictTakenF !== 1'b0) begin errors++; $display("FAIL b2b_104: got %b exp 0", PredictTakenF); end
    PCF = 32'h108; #1;
    checks++; if (PredictTakenF !== 1'b1 || PredictTargetF !== 32'h700) begin errors++; $display("FAIL b2b_108: got %b/%h exp 1/700", PredictTakenF, PredictTargetF); end
    PCF = 32'h10C; #1;
    checks++; if (PredictTakenF !== 1'b1 || PredictTargetF !== 32'h600) begin errors++; $display("FAIL b2b_10c: got %b/%h exp 1/600", PredictTakenF, PredictTargetF); end
    PCF = 32'h110; #1;
    checks++; if (PredictTakenF !== 1'b0 || PredictTargetF !== 32'h0) begin errors++; $display("FAIL b2b_110: got %b/%h exp 0/0", PredictTakenF, PredictTargetF); end
  endtask

  initial begin
    test_reset();
    test_branch_learn();
    test_mispredict_not_taken();
    test_jump();
    test_same_cycle();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
